// File: rtl/bb1_port_sched.sv
// Cycle scheduler for one K1802BB1 4x4 multiport register RAM: rotating-priority
// conflict-free grants, registered active-low port controls, read data two cycles after grant.
module bb1_port_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [3:0]  req_ready,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [3:0]  nEC,
  output logic [3:0]  nW,
  output logic [3:0]  nR,
  output logic [7:0]  ADDR,
  output logic [15:0] nDO,
  input  logic [15:0] nDI,
  output logic        nCI
);

  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant;
  logic [3:0]  wr_busy, rd_busy;
  logic [1:0]  idx, reg_sel;
  logic [1:0]  addr_arr [4];

  logic [3:0]  nec_q, nec_d;
  logic [3:0]  nw_q, nw_d;
  logic [3:0]  nr_q, nr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] ndo_q, ndo_d;
  logic [3:0]  rd_pend_q, rd_pend_d;
  logic [3:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      addr_arr[i] = req_addr[2*i +: 2];
    end
  end

  // Visit requesters from ptr; a register already written this cycle blocks
  // everything, one already read blocks only writes.
  always_comb begin
    grant   = '0;
    wr_busy = '0;
    rd_busy = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    reg_sel = '0;
    if (!reset) begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx     = ptr_q + 2'(k);
        reg_sel = addr_arr[idx];
        if (req_valid[idx]) begin
          if (req_write[idx]) begin
            if (!wr_busy[reg_sel] && !rd_busy[reg_sel]) begin
              grant[idx]       = 1'b1;
              wr_busy[reg_sel] = 1'b1;
              ptr_d            = idx + 2'd1;
            end
          end else if (!wr_busy[reg_sel]) begin
            grant[idx]       = 1'b1;
            rd_busy[reg_sel] = 1'b1;
            ptr_d            = idx + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    nec_d       = '1;
    nw_d        = '1;
    nr_d        = '1;
    addr_d      = addr_q;
    ndo_d       = '1;
    rd_pend_d   = grant & ~req_write;
    rsp_valid_d = rd_pend_q;
    rsp_rdata_d = rsp_rdata_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant[i]) begin
        nec_d[i]        = 1'b0;
        addr_d[2*i +: 2] = addr_arr[i];
        if (req_write[i]) begin
          nw_d[i]          = 1'b0;
          ndo_d[4*i +: 4]  = ~req_wdata[4*i +: 4];
        end else begin
          nr_d[i] = 1'b0;
        end
      end
      if (rd_pend_q[i]) begin
        rsp_rdata_d[4*i +: 4] = ~nDI[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      nec_q       <= '1;
      nw_q        <= '1;
      nr_q        <= '1;
      addr_q      <= '0;
      ndo_q       <= '1;
      rd_pend_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      nec_q       <= nec_d;
      nw_q        <= nw_d;
      nr_q        <= nr_d;
      addr_q      <= addr_d;
      ndo_q       <= ndo_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign nEC       = nec_q;
  assign nW        = nw_q;
  assign nR        = nr_q;
  assign ADDR      = addr_q;
  assign nDO       = ndo_q;
  assign nCI       = 1'b0;

endmodule

// File: tb/tb_bb1_port_sched.sv
// Bench for bb1_port_sched: behavioural K1802BB1 model on the port pins, table of
// per-cycle request vectors with expected grants, and a read-response scoreboard.
module tb_bb1_port_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata, rsp_rdata;
  logic [3:0]  nEC, nW, nR;
  logic [7:0]  ADDR;
  logic [15:0] nDO, nDI;
  logic        nCI;

  bb1_port_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .nEC(nEC), .nW(nW), .nR(nR), .ADDR(ADDR), .nDO(nDO), .nDI(nDI), .nCI(nCI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chip model: inverted data pins, write stored at the end of the strobe cycle.
  logic [3:0] chip_mem [4];
  always_comb begin
    nDI = '1;
    for (int i = 0; i < 4; i++)
      if (!nEC[i] && !nR[i]) nDI[4*i +: 4] = ~chip_mem[ADDR[2*i +: 2]];
  end
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (!nEC[j] && !nW[j]) chip_mem[ADDR[2*j +: 2]] <= ~nDO[4*j +: 4];
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [3:0]  er;
  } vec_t;

  typedef struct {
    int unsigned req;
    logic [3:0]  data;
    int unsigned due;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        sbq[$];
  rsp_t        e;
  logic [3:0]  ref_mem [4];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  ev;
  logic [15:0] ed;

  logic [3:0]  exp_nec, exp_nw, exp_nr;
  logic [7:0]  exp_addr;
  logic [15:0] exp_ndo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev = '0;
      ed = '0;
      while (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        ev[e.req] = 1'b1;
        ed[4*e.req +: 4] = e.data;
      end
      check("rsp_valid", {28'd0, rsp_valid}, {28'd0, ev});
      for (int k = 0; k < 4; k++)
        if (ev[k]) check($sformatf("rsp_rdata[%0d]", k), {28'd0, rsp_rdata[4*k +: 4]},
                         {28'd0, ed[4*k +: 4]});
    end
  end

  task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] w,
                      input logic [7:0] a, input logic [15:0] d, input logic [3:0] er,
                      input string nm);
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (rst) sbq.delete();
    #1;
    check({nm, " ready"}, {28'd0, req_ready}, {28'd0, er});
    @(posedge clk);
    #1;
    if (rst) begin
      exp_nec = '1; exp_nw = '1; exp_nr = '1; exp_addr = '0; exp_ndo = '1;
    end else begin
      exp_nec = ~er;
      exp_nw  = '1;
      exp_nr  = '1;
      exp_ndo = '1;
      for (int i = 0; i < 4; i++) begin
        if (er[i]) begin
          exp_addr[2*i +: 2] = a[2*i +: 2];
          if (w[i]) begin
            exp_nw[i] = 1'b0;
            exp_ndo[4*i +: 4] = ~d[4*i +: 4];
          end else begin
            exp_nr[i] = 1'b0;
            sbq.push_back('{req: i, data: ref_mem[a[2*i +: 2]], due: cyc + 1});
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (er[i] && w[i]) ref_mem[a[2*i +: 2]] = d[4*i +: 4];
    end
    check({nm, " nEC"},  {28'd0, nEC},  {28'd0, exp_nec});
    check({nm, " nW"},   {28'd0, nW},   {28'd0, exp_nw});
    check({nm, " nR"},   {28'd0, nR},   {28'd0, exp_nr});
    check({nm, " ADDR"}, {24'd0, ADDR}, {24'd0, exp_addr});
    check({nm, " nDO"},  {16'd0, nDO},  {16'd0, exp_ndo});
    check({nm, " nCI"},  {31'd0, nCI},  32'd0);
  endtask

  function automatic void add(input logic [3:0] v, input logic [3:0] w, input logic [7:0] a,
                              input logic [15:0] d, input logic [3:0] er);
    tbl.push_back('{v: v, w: w, a: a, d: d, er: er});
  endfunction

  initial begin
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;
    step(1'b1, 4'hF, 4'h0, 8'h00, 16'h0000, 4'h0, "rst0");
    step(1'b1, 4'hF, 4'hF, 8'h00, 16'h0000, 4'h0, "rst1");
    check("rst rsp_valid", {28'd0, rsp_valid}, 32'd0);
    check("rst rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    mon_en = 1'b1;

    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);   // idle
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'hF, 4'hF, 8'hE4, 16'h7CA5, 4'hF);   // r0..r3 = 5,A,C,7, no conflict
    add(4'h1, 4'h1, 8'h02, 16'h0009, 4'h1);   // req0 writes r2 = 9
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'h2, 4'h0, 8'h08, 16'h0000, 4'h2);   // req1 reads r2
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'h8, 4'h0, 8'h00, 16'h0000, 4'h8);   // ptr 2 -> req3 reads r0, ptr 0
    add(4'hF, 4'hF, 8'h55, 16'h4321, 4'h1);   // all write r1 from ptr 0
    add(4'hE, 4'hE, 8'h55, 16'h4321, 4'h2);
    add(4'hC, 4'hC, 8'h55, 16'h4321, 4'h4);
    add(4'h8, 4'h8, 8'h55, 16'h4321, 4'h8);
    add(4'h2, 4'h0, 8'h55, 16'h0000, 4'h2);   // req1 reads r1 = 4, ptr 2
    add(4'hF, 4'hF, 8'h55, 16'h4321, 4'h4);   // all write r1 from ptr 2
    add(4'hB, 4'hB, 8'h55, 16'h4321, 4'h8);
    add(4'h3, 4'h3, 8'h55, 16'h4321, 4'h1);
    add(4'h2, 4'h2, 8'h55, 16'h4321, 4'h2);
    add(4'h8, 4'h0, 8'h55, 16'h0000, 4'h8);   // req3 reads r1 = 2, ptr 0
    add(4'hF, 4'h1, 8'h3F, 16'h000B, 4'h9);   // w r3 blocks reads of r3
    add(4'h6, 4'h0, 8'h3F, 16'h0000, 4'h6);   // shared reads of new r3
    add(4'h1, 4'h0, 8'h02, 16'h0000, 4'h1);   // ptr 3 -> 1
    add(4'h6, 4'h4, 8'h00, 16'h0300, 4'h2);   // read r0 blocks write r0
    add(4'h4, 4'h4, 8'h00, 16'h0300, 4'h4);
    add(4'h8, 4'h8, 8'h40, 16'h0000, 4'h8);   // write data 0
    add(4'h1, 4'h0, 8'h01, 16'h0000, 4'h1);
    add(4'h2, 4'h0, 8'h00, 16'h0000, 4'h2);   // back-to-back reads
    add(4'h2, 4'h0, 8'h00, 16'h0000, 4'h2);
    add(4'h4, 4'h4, 8'h20, 16'h0E00, 4'h4);   // write then read next cycle
    add(4'h8, 4'h0, 8'h80, 16'h0000, 4'h8);
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);
    add(4'h0, 4'h0, 8'h00, 16'h0000, 4'h0);

    foreach (tbl[k])
      step(1'b0, tbl[k].v, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].er, $sformatf("v%0d", k));

    // Read in flight when reset arrives must never respond.
    step(1'b0, 4'h1, 4'h0, 8'h03, 16'h0000, 4'h1, "pre-rst read");
    step(1'b1, 4'h1, 4'h0, 8'h03, 16'h0000, 4'h0, "mid rst");
    step(1'b0, 4'h0, 4'h0, 8'h00, 16'h0000, 4'h0, "post rst0");
    step(1'b0, 4'h0, 4'h0, 8'h00, 16'h0000, 4'h0, "post rst1");
    step(1'b0, 4'h4, 4'h0, 8'h20, 16'h0000, 4'h4, "post rst read");
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'h0, 4'h0, 8'h00, 16'h0000, 4'h0, "drain");

    check("scoreboard empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
